// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Instruction-memory request/response bus between fetch and imem.
// Revision : 1.0
// ============================================================================
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Single-outstanding-request instruction fetch with IF/ID register.
// Revision : 1.0
// ============================================================================
module fetch_unit (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [31:0] PC,
  input  wire logic        StallD,
  input  wire logic        FlushD,
  fetch_unit_if.master     imem,
  output logic [31:0]      PCF,
  output logic [31:0]      PCPlus4F,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic [31:0]      PCPlus8D,
  output logic             ValidD,
  output logic             FetchBusyF
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pcf;
  logic [31:0] r_hold;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc4_d;
  logic [31:0] r_pc8_d;
  logic        r_valid_d;

  logic        w_allow;
  logic        w_avail;
  logic        w_xfer;
  logic [31:0] w_word;
  logic [31:0] w_pc4;
  logic [31:0] w_pc8;

  assign w_allow = !StallD && !FlushD;
  // An instruction is ready either from the live response or the holding register.
  assign w_avail = (r_state == S_HOLD) || ((r_state == S_WAIT) && imem.imem_rvalid);
  assign w_xfer  = w_avail && w_allow;
  assign w_word  = (r_state == S_HOLD) ? r_hold : imem.imem_rdata;
  assign w_pc4   = r_pcf + 32'd4;
  assign w_pc8   = r_pcf + 32'd8;

  assign imem.imem_req  = (r_state == S_REQ);
  assign imem.imem_addr = {r_pcf[31:2], 2'b00};

  assign PCF        = r_pcf;
  assign PCPlus4F   = w_pc4;
  assign FetchBusyF = !w_avail;
  assign InstrD     = r_instr_d;
  assign PCPlus4D   = r_pc4_d;
  assign PCPlus8D   = r_pc8_d;
  assign ValidD     = r_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_REQ;
      r_pcf   <= 32'd0;
      r_hold  <= 32'd0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem.imem_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (w_allow) begin
              r_pcf   <= PC;
              r_state <= S_REQ;
            end else begin
              r_hold  <= imem.imem_rdata;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_allow) begin
            r_pcf   <= PC;
            r_state <= S_REQ;
          end
        end
        default: begin
          r_state <= S_REQ;
        end
      endcase
    end
  end

  // Flush wins over stall; an unstalled cycle with nothing to deliver inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_d <= 32'd0;
      r_pc4_d   <= 32'd0;
      r_pc8_d   <= 32'd0;
      r_valid_d <= 1'b0;
    end else if (FlushD) begin
      r_instr_d <= 32'd0;
      r_pc4_d   <= 32'd0;
      r_pc8_d   <= 32'd0;
      r_valid_d <= 1'b0;
    end else if (!StallD) begin
      if (w_xfer) begin
        r_instr_d <= w_word;
        r_pc4_d   <= w_pc4;
        r_pc8_d   <= w_pc8;
        r_valid_d <= 1'b1;
      end else begin
        r_instr_d <= 32'd0;
        r_pc4_d   <= 32'd0;
        r_pc8_d   <= 32'd0;
        r_valid_d <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed scenarios plus randomized run against a flag-level model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        StallD;
  logic        FlushD;
  logic [31:0] PCF, PCPlus4F, InstrD, PCPlus4D, PCPlus8D;
  logic        ValidD, FetchBusyF;

  always #5 clk = ~clk;

  fetch_unit_if imem();

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .PC         (PC),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .imem       (imem),
    .PCF        (PCF),
    .PCPlus4F   (PCPlus4F),
    .InstrD     (InstrD),
    .PCPlus4D   (PCPlus4D),
    .PCPlus8D   (PCPlus8D),
    .ValidD     (ValidD),
    .FetchBusyF (FetchBusyF)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: fetch PC, "request accepted" flag, "word held" flag, decode slot.
  logic [31:0] m_pc, m_word, m_instr, m_p4, m_p8;
  logic        m_valid, m_out, m_have;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0001;
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_word = 32'd0; m_instr = 32'd0; m_p4 = 32'd0; m_p8 = 32'd0;
    m_valid = 1'b0; m_out = 1'b0; m_have = 1'b0;
  endtask

  task automatic model_step();
    logic        req, avail;
    logic [31:0] word;
    req   = !m_out && !m_have;
    avail = m_have || (m_out && imem.imem_rvalid);
    word  = m_have ? m_word : imem.imem_rdata;
    if (FlushD) begin
      m_instr = 32'd0; m_p4 = 32'd0; m_p8 = 32'd0; m_valid = 1'b0;
    end else if (!StallD) begin
      if (avail) begin
        m_instr = word; m_p4 = m_pc + 32'd4; m_p8 = m_pc + 32'd8; m_valid = 1'b1;
      end else begin
        m_instr = 32'd0; m_p4 = 32'd0; m_p8 = 32'd0; m_valid = 1'b0;
      end
    end
    if (avail && !StallD && !FlushD) begin
      m_pc = PC; m_have = 1'b0; m_out = 1'b0;
    end else if (avail && !m_have) begin
      m_have = 1'b1; m_word = imem.imem_rdata; m_out = 1'b0;
    end
    if (req && imem.imem_ready) m_out = 1'b1;
  endtask

  task automatic tick();
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic f, input logic r, input logic v,
                       input logic [31:0] d, input logic [31:0] p);
    StallD = s; FlushD = f; imem.imem_ready = r; imem.imem_rvalid = v;
    imem.imem_rdata = d; PC = p;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic fetch_one(input logic [31:0] nxt);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, nxt);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, memw(m_pc), nxt);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    checks++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got %0h want 1", imem.imem_req); end
    checks++; if (imem.imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h want 0", imem.imem_addr); end
    checks++; if (FetchBusyF !== 1'b1) begin errors++; $display("FAIL reset_busy got %0h want 1", FetchBusyF); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", ValidD); end
    checks++; if (InstrD !== 32'd0) begin errors++; $display("FAIL reset_instr got %h want 0", InstrD); end
    checks++; if (PCF !== 32'd0) begin errors++; $display("FAIL reset_pcf got %h want 0", PCF); end
    checks++; if (PCPlus4F !== 32'd4) begin errors++; $display("FAIL reset_pcplus4f got %h want 4", PCPlus4F); end
    tick();
    checks++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL reset_no_accept got %0h want 1", imem.imem_req); end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = 32'(4 * i);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, a + 32'd4);
      checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== a) begin errors++; $display("FAIL seq_req got %0h/%h want 1/%h", imem.imem_req, imem.imem_addr, a); end
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b1, memw(a), a + 32'd4);
      checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL seq_bubble got %0h want 0", ValidD); end
      checks++; if (imem.imem_req !== 1'b0 || FetchBusyF !== 1'b0) begin errors++; $display("FAIL seq_wait got req %0h busy %0h want 0/0", imem.imem_req, FetchBusyF); end
      tick();
      checks++; if (ValidD !== 1'b1 || InstrD !== memw(a)) begin errors++; $display("FAIL seq_instr got %0h/%h want 1/%h", ValidD, InstrD, memw(a)); end
      checks++; if (PCPlus4D !== a + 32'd4 || PCPlus8D !== a + 32'd8) begin errors++; $display("FAIL seq_pcd got %h/%h want %h/%h", PCPlus4D, PCPlus8D, a + 32'd4, a + 32'd8); end
      checks++; if (PCF !== a + 32'd4) begin errors++; $display("FAIL seq_pcf got %h want %h", PCF, a + 32'd4); end
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    fetch_one(32'd4);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd8);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hA1B2C3D4, 32'd8);
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++; if (imem.imem_req !== 1'b0 || FetchBusyF !== 1'b0) begin errors++; $display("FAIL hold_state got req %0h busy %0h want 0/0", imem.imem_req, FetchBusyF); end
      checks++; if (PCF !== 32'd4 || ValidD !== 1'b0) begin errors++; $display("FAIL hold_frozen got pcf %h valid %0h want 4/0", PCF, ValidD); end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd8);
      tick();
    end
    checks++; if (imem.imem_req !== 1'b0 || PCF !== 32'd4) begin errors++; $display("FAIL hold_end got req %0h pcf %h want 0/4", imem.imem_req, PCF); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd8);
    tick();
    checks++; if (InstrD !== 32'hA1B2C3D4 || ValidD !== 1'b1) begin errors++; $display("FAIL hold_xfer got %h/%0h want a1b2c3d4/1", InstrD, ValidD); end
    checks++; if (PCPlus4D !== 32'd8 || PCPlus8D !== 32'd12 || PCF !== 32'd8) begin errors++; $display("FAIL hold_pcs got %h/%h/%h want 8/c/8", PCPlus4D, PCPlus8D, PCF); end
    checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'd8) begin errors++; $display("FAIL hold_rereq got %0h/%h want 1/8", imem.imem_req, imem.imem_addr); end
  endtask

  task automatic test_flush();
    do_reset();
    fetch_one(32'd4);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd8);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0BADF00D, 32'd8);
    tick();
    checks++; if (ValidD !== 1'b1 || InstrD !== memw(32'd0)) begin errors++; $display("FAIL flush_pre got %0h/%h want 1/%h", ValidD, InstrD, memw(32'd0)); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd8);
    tick();
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'd0 || PCPlus8D !== 32'd0) begin errors++; $display("FAIL flush_bubble got %0h/%h/%h want 0/0/0", ValidD, InstrD, PCPlus8D); end
    checks++; if (imem.imem_req !== 1'b0 || PCF !== 32'd4) begin errors++; $display("FAIL flush_hold got req %0h pcf %h want 0/4", imem.imem_req, PCF); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd8);
    tick();
    checks++; if (ValidD !== 1'b0 || PCF !== 32'd4) begin errors++; $display("FAIL flush_only got %0h/%h want 0/4", ValidD, PCF); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd8);
    tick();
    checks++; if (InstrD !== 32'h0BADF00D || ValidD !== 1'b1 || PCPlus4D !== 32'd8 || PCF !== 32'd8) begin errors++; $display("FAIL flush_xfer got %h/%0h/%h/%h want 0badf00d/1/8/8", InstrD, ValidD, PCPlus4D, PCF); end
  endtask

  task automatic test_jump();
    do_reset();
    fetch_one(32'd4);
    fetch_one(32'd8);
    fetch_one(32'h00400100);
    checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h00400100) begin errors++; $display("FAIL jump_addr got %0h/%h want 1/00400100", imem.imem_req, imem.imem_addr); end
    checks++; if (PCPlus8D !== 32'h10 || PCPlus4D !== 32'hC || InstrD !== memw(32'd8)) begin errors++; $display("FAIL jump_d got %h/%h/%h want 10/c/%h", PCPlus8D, PCPlus4D, InstrD, memw(32'd8)); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    fetch_one(32'h100);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h104);
    tick();
    checks++; if (imem.imem_req !== 1'b0 || PCF !== 32'h100) begin errors++; $display("FAIL mrst_wait got %0h/%h want 0/100", imem.imem_req, PCF); end
    rst = 1'b1;
    #1;
    checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'd0 || PCF !== 32'd0 || FetchBusyF !== 1'b1) begin errors++; $display("FAIL mrst_async got %0h/%h/%h/%0h want 1/0/0/1", imem.imem_req, imem.imem_addr, PCF, FetchBusyF); end
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'd4);
    tick();
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'd0) begin errors++; $display("FAIL mrst_stray got %0h/%h want 0/0", ValidD, InstrD); end
    checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'd0) begin errors++; $display("FAIL mrst_rereq got %0h/%h want 1/0", imem.imem_req, imem.imem_addr); end
    fetch_one(32'd4);
    checks++; if (InstrD !== memw(32'd0) || ValidD !== 1'b1) begin errors++; $display("FAIL mrst_refetch got %h/%0h want %h/1", InstrD, ValidD, memw(32'd0)); end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_one(32'hFFFFFFFC);
    checks++; if (PCF !== 32'hFFFFFFFC || PCPlus4F !== 32'd0 || imem.imem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_f got %h/%h/%h want fffffffc/0/fffffffc", PCF, PCPlus4F, imem.imem_addr); end
    fetch_one(32'd0);
    checks++; if (PCPlus4D !== 32'd0 || PCPlus8D !== 32'd4 || InstrD !== memw(32'hFFFFFFFC)) begin errors++; $display("FAIL wrap_d got %h/%h/%h want 0/4/%h", PCPlus4D, PCPlus8D, InstrD, memw(32'hFFFFFFFC)); end
  endtask

  task automatic test_random();
    int          lat;
    logic        s, f, r, v;
    logic [31:0] d, nxt, tmp;
    lat = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      s = ($urandom_range(3) == 0);
      f = ($urandom_range(7) == 0);
      r = 1'($urandom_range(1));
      if (m_out) begin
        v = (lat == 0);
        if (lat > 0) lat--;
      end else begin
        v = !m_have && ($urandom_range(7) == 0);
      end
      d = v ? (m_out ? memw(m_pc) : 32'hDEADBEEF) : $urandom;
      tmp = $urandom;
      tmp[1:0] = 2'b00;
      nxt = ($urandom_range(15) == 0) ? tmp : m_pc + 32'd4;
      drive(s, f, r, v, d, nxt);
      checks++; if (imem.imem_req !== (!m_out && !m_have)) begin errors++; $display("FAIL rnd_req cyc %0d got %0h want %0h", n, imem.imem_req, !m_out && !m_have); end
      checks++; if (PCF !== m_pc || PCPlus4F !== m_pc + 32'd4 || imem.imem_addr !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h/%h/%h want %h", n, PCF, PCPlus4F, imem.imem_addr, m_pc); end
      checks++; if (FetchBusyF !== !(m_have || (m_out && v))) begin errors++; $display("FAIL rnd_busy cyc %0d got %0h want %0h", n, FetchBusyF, !(m_have || (m_out && v))); end
      checks++; if (InstrD !== m_instr || PCPlus4D !== m_p4 || PCPlus8D !== m_p8 || ValidD !== m_valid) begin errors++; $display("FAIL rnd_ifid cyc %0d got %h/%h/%h/%0h want %h/%h/%h/%0h", n, InstrD, PCPlus4D, PCPlus8D, ValidD, m_instr, m_p4, m_p8, m_valid); end
      if (!m_out && !m_have && r) lat = $urandom_range(3);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    test_reset();
    test_sequential();
    test_stall_hold();
    test_flush();
    test_jump();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  single system clock; all state updates on posedge clk.
REQ-002 rst  input  1  asynchronous, active-high reset; takes effect immediately, independent of clk.
REQ-003 PC  input  32  next-PC value supplied by the writeback/PC-select logic, derived from PCPlus4F.
REQ-004 StallD  input  1  decode stage frozen; the IF/ID register holds its contents.
REQ-005 FlushD  input  1  convert the IF/ID contents to a bubble.
REQ-006 imem_req  output  1  instruction-memory request valid.
REQ-007 imem_addr  output  32  request address, word aligned.
REQ-008 imem_ready  input  1  memory accepts the request in this cycle.
REQ-009 imem_rvalid  input  1  read data valid.
REQ-010 imem_rdata  input  32  returned instruction word.
REQ-011 PCF  output  32  current fetch PC.
REQ-012 PCPlus4F  output  32  PCF+4, combinational.
REQ-013 InstrD, PCPlus4D, PCPlus8D  output  32 each  IF/ID pipeline register contents.
REQ-014 ValidD  output  1  the IF/ID register holds a real instruction.
REQ-015 FetchBusyF  output  1  high while no instruction is ready to enter decode.

Function
REQ-016 States SHALL be REQ, WAIT and HOLD; at most one request is outstanding at any time.
REQ-017 REQ: imem_req=1 and imem_addr=PCF; on imem_ready the FSM goes to WAIT; imem_rvalid is ignored in REQ.
REQ-018 WAIT: imem_req=0; imem_rvalid=0 keeps the FSM in WAIT.
REQ-019 WAIT with imem_rvalid=1 and a transfer allowed (see REQ-023): the IF/ID register loads imem_rdata, PCF+4 and PCF+8; ValidD<=1; PCF<=PC; next state REQ.
REQ-020 WAIT with imem_rvalid=1 and no transfer allowed: imem_rdata is captured into a 32-bit holding register; next state HOLD.
REQ-021 HOLD: imem_req=0; when a transfer is allowed, the IF/ID register loads the held word with PCF+4 and PCF+8; ValidD<=1; PCF<=PC; next state REQ.
REQ-022 PCF SHALL change only on a transfer; a request is never reissued for the same PCF.
REQ-023 A transfer is allowed when StallD=0 and FlushD=0.
REQ-024 FlushD=1 SHALL force InstrD=0, PCPlus4D=0, PCPlus8D=0 and ValidD=0 on the next edge, regardless of StallD.
REQ-025 During FlushD=1 the fetched or held word is retained and transfers on the first later cycle in which a transfer is allowed.
REQ-026 If StallD=0, FlushD=0 and no instruction is available (state REQ, or WAIT without imem_rvalid), the IF/ID register SHALL load a bubble: all fields 0, ValidD=0.
REQ-027 StallD=1 with FlushD=0 SHALL leave the IF/ID register unchanged.
REQ-028 FetchBusyF=1 in REQ, and in WAIT without imem_rvalid; otherwise 0.
REQ-029 PC+4 and PC+8 SHALL be computed modulo 2^32; wrap from 32'hFFFFFFFC gives 32'h00000000.
REQ-030 The block does no branch or jump squashing; the delay slot is architectural, and the instruction after a branch is always delivered.

Reset
REQ-031 rst=1 SHALL immediately set state=REQ, PCF=32'h00000000, the holding register to 0, the IF/ID fields to 0 and ValidD=0.
REQ-032 During rst=1 the outputs SHALL be imem_req=1, imem_addr=0 and FetchBusyF=1; the memory request is not considered accepted until rst=0.
REQ-033 A mid-operation reset SHALL abandon any outstanding request; a response arriving afterwards in REQ is ignored per REQ-017.

Verification
REQ-034 Reset release, memory always ready, imem_rvalid one cycle after accept, PC=PCPlus4F:
  - InstrD sequence follows addresses 0, 4, 8;
  - ValidD alternates 1 and 0 (bubble while waiting).
REQ-035 imem_rvalid arrives with StallD=1 for 3 cycles:
  - state=HOLD and PCF unchanged;
  - the word enters InstrD on the cycle after StallD falls;
  - no new request before that.
REQ-036 FlushD=1 while ValidD=1 and StallD=1:
  - next cycle ValidD=0 and InstrD=0;
  - the pending word transfers once FlushD=0.
REQ-037 PC=32'h00400100 (jump target) presented at transfer of the word from 0x8:
  - next imem_addr=0x00400100;
  - PCPlus8D=0x10.
REQ-038 rst pulsed while in WAIT, then a stray imem_rvalid with data 32'hDEADBEEF:
  - ValidD stays 0;
  - imem_addr=0 and is re-requested.
REQ-039 PCF=32'hFFFFFFFC:
  - PCPlus4D=0 and PCPlus8D=4 after transfer.
